// File: rtl/dispatcher_pkg.sv
// Shared opcode constants, instruction classes and issue-entry layout for the dispatcher.
package dispatcher_pkg;

  localparam int FIELD_WIDTH = 55;

  localparam logic [6:0] OP_OP       = 7'b0110011;
  localparam logic [6:0] OP_IMM      = 7'b0010011;
  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_LOAD_FP  = 7'b0000111;
  localparam logic [6:0] OP_STORE_FP = 7'b0100111;
  localparam logic [6:0] OP_FP       = 7'b1010011;
  localparam logic [6:0] OP_FMADD    = 7'b1000011;
  localparam logic [6:0] OP_FMSUB    = 7'b1000111;
  localparam logic [6:0] OP_FNMSUB   = 7'b1001011;
  localparam logic [6:0] OP_FNMADD   = 7'b1001111;

  typedef enum logic [1:0] {INT, FP, AGU, ILLEGAL} iclass_e;

  typedef enum logic [2:0] {FMT_R, FMT_R4, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} fmt_e;

  localparam int ENT_VALID  = 54;
  localparam int ENT_IMM_F  = 53;
  localparam int ENT_RD_HI  = 52;
  localparam int ENT_RD_LO  = 48;
  localparam int ENT_F3_HI  = 47;
  localparam int ENT_F3_LO  = 45;
  localparam int ENT_F7B5   = 44;
  localparam int ENT_OPA_HI = 43;
  localparam int ENT_OPA_LO = 12;
  localparam int ENT_IMM_HI = 11;
  localparam int ENT_IMM_LO = 0;

  function automatic iclass_e classify(input logic [6:0] op, input logic fp_en);
    case (op)
      OP_OP, OP_IMM, OP_LUI, OP_AUIPC, OP_BRANCH, OP_JAL, OP_JALR: return INT;
      OP_LOAD, OP_STORE, OP_LOAD_FP, OP_STORE_FP:                  return AGU;
      OP_FP, OP_FMADD, OP_FMSUB, OP_FNMSUB, OP_FNMADD:             return fp_en ? FP : ILLEGAL;
      default:                                                     return ILLEGAL;
    endcase
  endfunction

  // Illegal opcodes fall back to FMT_R; they are discarded before the format matters.
  function automatic fmt_e decode_fmt(input logic [6:0] op);
    case (op)
      OP_IMM, OP_LOAD, OP_JALR, OP_LOAD_FP:       return FMT_I;
      OP_STORE, OP_STORE_FP:                      return FMT_S;
      OP_BRANCH:                                  return FMT_B;
      OP_LUI, OP_AUIPC:                           return FMT_U;
      OP_JAL:                                     return FMT_J;
      OP_FMADD, OP_FMSUB, OP_FNMSUB, OP_FNMADD:   return FMT_R4;
      default:                                    return FMT_R;
    endcase
  endfunction

endpackage

// File: rtl/dispatch_fifo.sv
// Parameterized FIFO used for the fetch queue and every issue queue; head reads as zero when empty.
module dispatch_fifo #(
  parameter int WIDTH = 55,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  // A push is judged against the occupancy before this edge, so a pop cannot free room for it.
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = empty ? '0 : mem[rd_ptr];

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/dispatcher.sv
// In-order dispatcher: fetch queue -> decode/hazard check -> INT/FP/AGU issue queues.
// Define DISPATCHER_FP_EN to build the floating-point issue queue; otherwise FP opcodes are discarded.
module dispatcher #(
  parameter int XLEN        = 32,
  parameter int FIELD_WIDTH = dispatcher_pkg::FIELD_WIDTH,
  parameter int IFQ_DEPTH   = 8,
  parameter int IQ_DEPTH    = 4
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   enq_ifq,
  input  logic                   deq_ifq,
  input  logic [XLEN-1:0]        data_in_ifq,
  output logic                   full_ifq,
  output logic                   empty_ifq,
  output logic                   full_intalu,
  output logic                   full_fpalu,
  output logic                   full_agu,
  input  logic                   alu_ready_i,
  input  logic                   fpalu_ready_i,
  input  logic                   agu_ready_i,
  output logic [4:0]             rs1_sel,
  output logic [4:0]             rs2_sel,
  output logic [4:0]             rd_sel,
  input  logic [XLEN:0]          rs1_i,
  input  logic [XLEN:0]          rs2_i,
  input  logic [XLEN:0]          rd_i,
  output logic [FIELD_WIDTH-1:0] intalu_data_o,
  output logic [FIELD_WIDTH-1:0] fpalu_data_o,
  output logic [FIELD_WIDTH-1:0] agu_data_o
);

  import dispatcher_pkg::*;

`ifdef DISPATCHER_FP_EN
  localparam logic FP_EN = 1'b1;
`else
  localparam logic FP_EN = 1'b0;
`endif

  logic [XLEN-1:0]        head_p0;
  iclass_e                cls_p0;
  fmt_e                   fmt_p0;
  logic                   rs1_used_p0;
  logic                   rs2_used_p0;
  logic                   rd_used_p0;
  logic                   uses_imm_p0;
  logic                   hazard_p0;
  logic                   tgt_full_p0;
  logic                   req_p0;
  logic                   vld_p0;
  logic                   ifq_pop_p0;
  logic [11:0]            imm_p0;
  logic [FIELD_WIDTH-1:0] entry_p0;
  logic                   push_int;
  logic                   push_fp;
  logic                   push_agu;
  logic                   unused_inputs;

  dispatch_fifo #(.WIDTH(XLEN), .DEPTH(IFQ_DEPTH)) u_ifq (
    .clk    (clk),
    .resetn (resetn),
    .push   (enq_ifq),
    .pop    (ifq_pop_p0),
    .din    (data_in_ifq),
    .dout   (head_p0),
    .full   (full_ifq),
    .empty  (empty_ifq)
  );

  // p0: decode the fetch-queue head, check hazards and build the issue entry
  assign rs1_sel = head_p0[19:15];
  assign rs2_sel = head_p0[24:20];
  assign rd_sel  = head_p0[11:7];

  always_comb begin
    cls_p0      = classify(head_p0[6:0], FP_EN);
    fmt_p0      = decode_fmt(head_p0[6:0]);
    rs1_used_p0 = !(fmt_p0 inside {FMT_U, FMT_J});
    rs2_used_p0 = fmt_p0 inside {FMT_R, FMT_S, FMT_B};
    rd_used_p0  = !(fmt_p0 inside {FMT_S, FMT_B});
    uses_imm_p0 = fmt_p0 inside {FMT_I, FMT_S, FMT_U, FMT_J};

    hazard_p0 = (rs1_used_p0 && (rs1_sel != 5'd0) && rs1_i[XLEN]) ||
                (rs2_used_p0 && (rs2_sel != 5'd0) && rs2_i[XLEN]) ||
                (rd_used_p0  && (rd_sel  != 5'd0) && rd_i[XLEN]);

    case (cls_p0)
      INT:     tgt_full_p0 = full_intalu;
      FP:      tgt_full_p0 = full_fpalu;
      AGU:     tgt_full_p0 = full_agu;
      default: tgt_full_p0 = 1'b1;
    endcase

    case (fmt_p0)
      FMT_I, FMT_U, FMT_J: imm_p0 = head_p0[31:20];
      FMT_S:               imm_p0 = {head_p0[31:25], head_p0[11:7]};
      default:             imm_p0 = {7'b0, head_p0[24:20]};
    endcase

    entry_p0                          = '0;
    entry_p0[ENT_VALID]               = 1'b1;
    entry_p0[ENT_IMM_F]               = uses_imm_p0;
    entry_p0[ENT_RD_HI:ENT_RD_LO]     = rd_used_p0 ? head_p0[11:7] : 5'd0;
    entry_p0[ENT_F3_HI:ENT_F3_LO]     = head_p0[14:12];
    entry_p0[ENT_F7B5]                = head_p0[30];
    entry_p0[ENT_OPA_HI:ENT_OPA_LO]   = rs1_used_p0 ? rs1_i[31:0] : 32'd0;
    entry_p0[ENT_IMM_HI:ENT_IMM_LO]   = imm_p0;

    // Illegal heads are dropped; stalled legal heads stay put until hazard and space clear.
    req_p0     = deq_ifq && !empty_ifq;
    vld_p0     = req_p0 && (cls_p0 != ILLEGAL) && !hazard_p0 && !tgt_full_p0;
    ifq_pop_p0 = vld_p0 || (req_p0 && (cls_p0 == ILLEGAL));
    push_int   = vld_p0 && (cls_p0 == INT);
    push_fp    = vld_p0 && (cls_p0 == FP);
    push_agu   = vld_p0 && (cls_p0 == AGU);
  end

  // p1: issue queues, head visible the cycle after dispatch
  dispatch_fifo #(.WIDTH(FIELD_WIDTH), .DEPTH(IQ_DEPTH)) u_intq (
    .clk    (clk),
    .resetn (resetn),
    .push   (push_int),
    .pop    (alu_ready_i),
    .din    (entry_p0),
    .dout   (intalu_data_o),
    .full   (full_intalu),
    .empty  ()
  );

  dispatch_fifo #(.WIDTH(FIELD_WIDTH), .DEPTH(IQ_DEPTH)) u_aguq (
    .clk    (clk),
    .resetn (resetn),
    .push   (push_agu),
    .pop    (agu_ready_i),
    .din    (entry_p0),
    .dout   (agu_data_o),
    .full   (full_agu),
    .empty  ()
  );

`ifdef DISPATCHER_FP_EN
  dispatch_fifo #(.WIDTH(FIELD_WIDTH), .DEPTH(IQ_DEPTH)) u_fpq (
    .clk    (clk),
    .resetn (resetn),
    .push   (push_fp),
    .pop    (fpalu_ready_i),
    .din    (entry_p0),
    .dout   (fpalu_data_o),
    .full   (full_fpalu),
    .empty  ()
  );

  assign unused_inputs = ^{rs2_i[XLEN-1:0], rd_i[XLEN-1:0]};
`else
  assign full_fpalu    = 1'b0;
  assign fpalu_data_o  = '0;
  assign unused_inputs = ^{rs2_i[XLEN-1:0], rd_i[XLEN-1:0], fpalu_ready_i, push_fp};
`endif

endmodule

// File: tb/tb_dispatcher.sv
// Self-checking bench for dispatcher: directed scenarios plus randomized traffic against a queue model.
module tb_dispatcher;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        enq_ifq = 1'b0;
  logic        deq_ifq = 1'b0;
  logic [31:0] data_in_ifq = '0;
  logic        full_ifq, empty_ifq, full_intalu, full_fpalu, full_agu;
  logic        alu_ready_i = 1'b0;
  logic        fpalu_ready_i = 1'b0;
  logic        agu_ready_i = 1'b0;
  logic [4:0]  rs1_sel, rs2_sel, rd_sel;
  logic [32:0] rs1_i = '0;
  logic [32:0] rs2_i = '0;
  logic [32:0] rd_i = '0;
  logic [54:0] intalu_data_o, fpalu_data_o, agu_data_o;

  int checks = 0;
  int failures = 0;

`ifdef DISPATCHER_FP_EN
  localparam bit FP_EN = 1'b1;
`else
  localparam bit FP_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  dispatcher #(.XLEN(32), .FIELD_WIDTH(55), .IFQ_DEPTH(8), .IQ_DEPTH(4)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .enq_ifq       (enq_ifq),
    .deq_ifq       (deq_ifq),
    .data_in_ifq   (data_in_ifq),
    .full_ifq      (full_ifq),
    .empty_ifq     (empty_ifq),
    .full_intalu   (full_intalu),
    .full_fpalu    (full_fpalu),
    .full_agu      (full_agu),
    .alu_ready_i   (alu_ready_i),
    .fpalu_ready_i (fpalu_ready_i),
    .agu_ready_i   (agu_ready_i),
    .rs1_sel       (rs1_sel),
    .rs2_sel       (rs2_sel),
    .rd_sel        (rd_sel),
    .rs1_i         (rs1_i),
    .rs2_i         (rs2_i),
    .rd_i          (rd_i),
    .intalu_data_o (intalu_data_o),
    .fpalu_data_o  (fpalu_data_o),
    .agu_data_o    (agu_data_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_ifq[$];
  logic [54:0] m_int[$];
  logic [54:0] m_fp[$];
  logic [54:0] m_agu[$];
  int          m_cycles = 0;

  function automatic string m_fmt(input logic [6:0] op);
    case (op)
      7'b0110011, 7'b1010011:                         return "R";
      7'b1000011, 7'b1000111, 7'b1001011, 7'b1001111: return "R4";
      7'b0010011, 7'b0000011, 7'b1100111, 7'b0000111: return "I";
      7'b0100011, 7'b0100111:                         return "S";
      7'b1100011:                                     return "B";
      7'b0110111, 7'b0010111:                         return "U";
      7'b1101111:                                     return "J";
      default:                                        return "X";
    endcase
  endfunction

  // 0 = integer ALU, 1 = FP ALU, 2 = AGU, -1 = discard
  function automatic int m_unit(input logic [6:0] op);
    string f;
    f = m_fmt(op);
    if (op inside {7'b0000011, 7'b0100011, 7'b0000111, 7'b0100111}) return 2;
    if (f == "R4" || op == 7'b1010011) return FP_EN ? 1 : -1;
    if (f == "X") return -1;
    return 0;
  endfunction

  function automatic bit m_hazard(input logic [31:0] w, input logic b1, input logic b2, input logic bd);
    string f;
    bit u1, u2, ud;
    f  = m_fmt(w[6:0]);
    u1 = !(f == "U" || f == "J");
    u2 = (f == "R" || f == "S" || f == "B");
    ud = !(f == "S" || f == "B");
    return (u1 && w[19:15] != 0 && b1) || (u2 && w[24:20] != 0 && b2) || (ud && w[11:7] != 0 && bd);
  endfunction

  function automatic logic [54:0] m_entry(input logic [31:0] w, input logic [31:0] v1);
    string       f;
    logic [11:0] imm;
    bit          uimm;
    f    = m_fmt(w[6:0]);
    uimm = (f == "I" || f == "S" || f == "U" || f == "J");
    if (f == "I" || f == "U" || f == "J") imm = w[31:20];
    else if (f == "S")                    imm = {w[31:25], w[11:7]};
    else                                  imm = {7'b0, w[24:20]};
    return {1'b1, uimm,
            (f == "S" || f == "B") ? 5'd0 : w[11:7],
            w[14:12], w[30],
            (f == "U" || f == "J") ? 32'd0 : v1,
            imm};
  endfunction

  always @(posedge clk) begin
    m_cycles++;
    if (resetn) begin
      m_ifq.delete();
      m_int.delete();
      m_fp.delete();
      m_agu.delete();
    end else begin
      automatic logic [31:0] h = (m_ifq.size() > 0) ? m_ifq[0] : 32'd0;
      automatic int          u = m_unit(h[6:0]);
      automatic bit          ifq_was_full = (m_ifq.size() == 8);
      automatic int          occ[3] = '{m_int.size(), m_fp.size(), m_agu.size()};
      automatic int          tgt = -1;
      automatic bit          pop_head = 1'b0;
      automatic logic [54:0] e = m_entry(h, rs1_i[31:0]);
      if (deq_ifq && m_ifq.size() > 0) begin
        if (u < 0) pop_head = 1'b1;
        else if (!m_hazard(h, rs1_i[32], rs2_i[32], rd_i[32]) && occ[u] < 4) begin
          pop_head = 1'b1;
          tgt = u;
        end
      end
      if (alu_ready_i && m_int.size() > 0)   void'(m_int.pop_front());
      if (fpalu_ready_i && m_fp.size() > 0)  void'(m_fp.pop_front());
      if (agu_ready_i && m_agu.size() > 0)   void'(m_agu.pop_front());
      if (tgt == 0) m_int.push_back(e);
      if (tgt == 1) m_fp.push_back(e);
      if (tgt == 2) m_agu.push_back(e);
      if (pop_head) void'(m_ifq.pop_front());
      if (enq_ifq && !ifq_was_full) m_ifq.push_back(data_in_ifq);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_cycles > 0) begin
      automatic logic [31:0] h = (m_ifq.size() > 0) ? m_ifq[0] : 32'd0;
      check("empty_ifq", 64'(empty_ifq), 64'(m_ifq.size() == 0));
      check("full_ifq", 64'(full_ifq), 64'(m_ifq.size() == 8));
      check("full_intalu", 64'(full_intalu), 64'(m_int.size() == 4));
      check("full_fpalu", 64'(full_fpalu), 64'(m_fp.size() == 4));
      check("full_agu", 64'(full_agu), 64'(m_agu.size() == 4));
      check("rs1_sel", 64'(rs1_sel), 64'(h[19:15]));
      check("rs2_sel", 64'(rs2_sel), 64'(h[24:20]));
      check("rd_sel", 64'(rd_sel), 64'(h[11:7]));
      check("intalu_data_o", 64'(intalu_data_o), 64'((m_int.size() > 0) ? m_int[0] : 55'd0));
      check("fpalu_data_o", 64'(fpalu_data_o), 64'((m_fp.size() > 0) ? m_fp[0] : 55'd0));
      check("agu_data_o", 64'(agu_data_o), 64'((m_agu.size() > 0) ? m_agu[0] : 55'd0));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] rand_reg();
    return ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops[20] = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1100011,
                             7'b1101111, 7'b1100111, 7'b0000011, 7'b0100011, 7'b0000111,
                             7'b0100111, 7'b1010011, 7'b1000011, 7'b1000111, 7'b1001011,
                             7'b1001111, 7'b0000000, 7'b1111111, 7'b0001111, 7'b1110011};
    logic [31:0] w;
    w        = $urandom;
    w[6:0]   = ops[$urandom_range(0, 19)];
    w[11:7]  = rand_reg();
    w[19:15] = rand_reg();
    w[24:20] = rand_reg();
    return w;
  endfunction

  initial begin
    // reset state
    resetn = 1'b1;
    step();
    step();
    resetn = 1'b0;
    check("rst_empty_ifq", 64'(empty_ifq), 64'd1);
    check("rst_full_ifq", 64'(full_ifq), 64'd0);
    check("rst_full_intalu", 64'(full_intalu), 64'd0);
    check("rst_full_agu", 64'(full_agu), 64'd0);
    check("rst_full_fpalu", 64'(full_fpalu), 64'd0);
    check("rst_intalu_data", 64'(intalu_data_o), 64'd0);
    check("rst_agu_data", 64'(agu_data_o), 64'd0);
    check("rst_fpalu_data", 64'(fpalu_data_o), 64'd0);
    check("rst_rs1_sel", 64'(rs1_sel), 64'd0);

    // fill the IFQ with discardable words carrying distinct register fields
    for (int i = 0; i < 8; i++) begin
      enq_ifq     = 1'b1;
      data_in_ifq = (32'(i) << 15) | (32'(i + 8) << 20) | (32'(i + 16) << 7);
      step();
    end
    check("ifq_full_after_8", 64'(full_ifq), 64'd1);
    data_in_ifq = 32'hFFFF_FF80;
    step();
    enq_ifq = 1'b0;
    check("ifq_full_after_9th", 64'(full_ifq), 64'd1);
    deq_ifq = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("ifq_order_rs1", 64'(rs1_sel), 64'(i));
      check("ifq_order_rs2", 64'(rs2_sel), 64'(i + 8));
      check("ifq_order_rd", 64'(rd_sel), 64'(i + 16));
      step();
    end
    deq_ifq = 1'b0;
    check("ifq_9th_dropped", 64'(empty_ifq), 64'd1);
    check("ifq_empty_sel", 64'(rd_sel), 64'd0);

    // ADDI x5, x1, 12
    rs1_i       = {1'b0, 32'd7};
    enq_ifq     = 1'b1;
    data_in_ifq = 32'h00C0_8293;
    step();
    enq_ifq = 1'b0;
    check("addi_rs1_sel", 64'(rs1_sel), 64'd1);
    check("addi_rd_sel", 64'(rd_sel), 64'd5);
    check("addi_not_yet", 64'(intalu_data_o), 64'd0);
    deq_ifq = 1'b1;
    step();
    deq_ifq = 1'b0;
    check("addi_valid", 64'(intalu_data_o[54]), 64'd1);
    check("addi_uses_imm", 64'(intalu_data_o[53]), 64'd1);
    check("addi_rd", 64'(intalu_data_o[52:48]), 64'd5);
    check("addi_funct3", 64'(intalu_data_o[47:45]), 64'd0);
    check("addi_operand", 64'(intalu_data_o[43:12]), 64'd7);
    check("addi_imm", 64'(intalu_data_o[11:0]), 64'd12);
    check("addi_entry", 64'(intalu_data_o), 64'h0065_0000_0000_700C);
    check("addi_ifq_empty", 64'(empty_ifq), 64'd1);
    alu_ready_i = 1'b1;
    step();
    alu_ready_i = 1'b0;
    check("addi_drained", 64'(intalu_data_o), 64'd0);

    // LW x2, 4(x3)
    rs1_i       = {1'b0, 32'h100};
    enq_ifq     = 1'b1;
    data_in_ifq = 32'h0041_A103;
    step();
    enq_ifq = 1'b0;
    deq_ifq = 1'b1;
    step();
    deq_ifq = 1'b0;
    check("lw_rd", 64'(agu_data_o[52:48]), 64'd2);
    check("lw_funct3", 64'(agu_data_o[47:45]), 64'd2);
    check("lw_imm", 64'(agu_data_o[11:0]), 64'd4);
    check("lw_uses_imm", 64'(agu_data_o[53]), 64'd1);
    check("lw_operand", 64'(agu_data_o[43:12]), 64'h100);
    check("lw_not_int", 64'(intalu_data_o), 64'd0);
    agu_ready_i = 1'b1;
    step();
    agu_ready_i = 1'b0;

    // hazard on rs1
    rs1_i       = {1'b1, 32'd9};
    enq_ifq     = 1'b1;
    data_in_ifq = 32'h00C0_8293;
    step();
    enq_ifq = 1'b0;
    deq_ifq = 1'b1;
    step();
    step();
    step();
    check("haz_head_kept", 64'(empty_ifq), 64'd0);
    check("haz_head_rs1", 64'(rs1_sel), 64'd1);
    check("haz_no_issue", 64'(intalu_data_o), 64'd0);
    rs1_i = {1'b0, 32'd9};
    step();
    deq_ifq = 1'b0;
    check("haz_clear_valid", 64'(intalu_data_o[54]), 64'd1);
    check("haz_clear_operand", 64'(intalu_data_o[43:12]), 64'd9);
    check("haz_clear_popped", 64'(empty_ifq), 64'd1);
    alu_ready_i = 1'b1;
    step();
    alu_ready_i = 1'b0;

    // backpressure: five ADDIs with rd = 1..5 into a stalled ALU queue
    for (int k = 1; k <= 5; k++) begin
      enq_ifq     = 1'b1;
      data_in_ifq = 32'h00C0_8013 | (32'(k) << 7);
      step();
    end
    enq_ifq = 1'b0;
    deq_ifq = 1'b1;
    for (int k = 0; k < 6; k++) step();
    check("bp_full_intalu", 64'(full_intalu), 64'd1);
    check("bp_stalled_head", 64'(rd_sel), 64'd5);
    check("bp_q_head_rd", 64'(intalu_data_o[52:48]), 64'd1);
    alu_ready_i = 1'b1;
    step();
    check("bp_pop1_rd", 64'(intalu_data_o[52:48]), 64'd2);
    check("bp_pop1_stall", 64'(empty_ifq), 64'd0);
    step();
    check("bp_pop2_rd", 64'(intalu_data_o[52:48]), 64'd3);
    check("bp_entered", 64'(empty_ifq), 64'd1);
    step();
    check("bp_pop3_rd", 64'(intalu_data_o[52:48]), 64'd4);
    step();
    check("bp_pop4_rd", 64'(intalu_data_o[52:48]), 64'd5);
    step();
    check("bp_drained", 64'(intalu_data_o), 64'd0);
    deq_ifq     = 1'b0;
    alu_ready_i = 1'b0;

    // randomized traffic, including occasional mid-stream resets
    for (int c = 0; c < 3000; c++) begin
      automatic int rdy_pct = ((c / 200) % 2 == 1) ? 20 : 80;
      resetn        = ($urandom_range(0, 99) == 0);
      enq_ifq       = ($urandom_range(0, 99) < 60);
      deq_ifq       = ($urandom_range(0, 99) < 70);
      data_in_ifq   = rand_instr();
      alu_ready_i   = ($urandom_range(0, 99) < rdy_pct);
      fpalu_ready_i = ($urandom_range(0, 99) < rdy_pct);
      agu_ready_i   = ($urandom_range(0, 99) < rdy_pct);
      rs1_i         = {($urandom_range(0, 4) == 0), 32'($urandom)};
      rs2_i         = {($urandom_range(0, 4) == 0), 32'($urandom)};
      rd_i          = {($urandom_range(0, 4) == 0), 32'($urandom)};
      step();
    end

    resetn  = 1'b0;
    enq_ifq = 1'b0;
    deq_ifq = 1'b0;
    step();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
